clock_interface: RTL and testbench

//  Core clock-enable generator feeding riscv_core on the DE2 board top level.

---
 rtl/clock_interface.sv | 201 ++++++++++++++++++++
 tb/tb_clock_interface.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_interface.sv
// clock_interface
//   Clock-enable generator for the core. Runs from the 50 MHz board clock and
//   emits a one-cycle cpu_clk_en_o pulse in one of four modes: manual
//   single-step (debounced push button), slow auto, medium auto, and free-run.
//   Also drives a tick LED and a 32-bit count of emitted pulses.
//   Optional feature macro: CLOCK_IF_BURST_EN. When it is defined, holding the
//   button in manual mode for BURST_HOLD cycles starts auto-repeat at the
//   MED_DIV rate. When it is undefined, each press gives exactly one pulse.
//   Reset is synchronous and active-high. All outputs are registered.
module clock_interface #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SLOW_DIV        = 50_000_000,
  parameter int MED_DIV         = 5_000_000,
  parameter int BURST_HOLD      = 25_000_000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  mode_i,
  input  logic        step_btn_i,
  input  logic        halt_i,
  output logic        cpu_clk_en_o,
  output logic        tick_led_o,
  output logic [31:0] step_count_o
);

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    SLOW   = 2'b01,
    MED    = 2'b10,
    FREE   = 2'b11
  } mode_e;

  localparam int DIV_MAX = (SLOW_DIV > MED_DIV) ? SLOW_DIV : MED_DIV;
  localparam int DB_W    = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_W   = ($clog2(DIV_MAX) > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] SLOW_LAST = DIV_W'(SLOW_DIV - 1);
  localparam logic [DIV_W-1:0] MED_LAST  = DIV_W'(MED_DIV - 1);

  // A divider or debounce limit below 2 leaves no room for a counted period.
  if (DEBOUNCE_CYCLES < 2 || SLOW_DIV < 2 || MED_DIV < 2 || BURST_HOLD < 2) begin : g_bad_params
    $error("clock_interface: timing parameters must all be >= 2");
  end

  // Synchronizers: two flops each for the raw button and mode switches.
  logic             btn_meta_q, btn_s_q;
  logic [1:0]       mode_meta_q, mode_s_q;

  // Debounce and edge detection.
  logic             btn_db_q, btn_db_d;
  logic             btn_db_prev_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             step_req_q, step_req_d;

  // Mode FSM, divider and output registers.
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             cpu_clk_en_q, cpu_clk_en_d;
  logic             tick_led_q, tick_led_d;
  logic [31:0]      step_count_q, step_count_d;

`ifdef CLOCK_IF_BURST_EN
  localparam int HOLD_W = ($clog2(BURST_HOLD + 1) > 1) ? $clog2(BURST_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(BURST_HOLD);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  // Debounce: the accepted state follows the synchronized button only after
  // it has differed for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // A step request is a single cycle on the press edge of the debounced button.
  assign step_req_d = btn_db_q & ~btn_db_prev_q;

  // Mode FSM: a mode change takes priority, then halt, then per-mode pulsing.
  always_comb begin
    mode_d       = mode_q;
    div_cnt_d    = div_cnt_q;
    cpu_clk_en_d = 1'b0;
`ifdef CLOCK_IF_BURST_EN
    hold_cnt_d   = '0;
`endif
    if (mode_s_q != mode_q) begin
      mode_d    = mode_e'(mode_s_q);
      div_cnt_d = '0;
    end else if (halt_i) begin
      // Divider holds so the auto modes resume mid-period; any step request
      // arriving now is dropped.
`ifdef CLOCK_IF_BURST_EN
      if (mode_q == MANUAL) div_cnt_d = '0;
`endif
    end else begin
      unique case (mode_q)
        MANUAL: begin
          cpu_clk_en_d = step_req_q;
`ifdef CLOCK_IF_BURST_EN
          if (btn_db_q) begin
            hold_cnt_d = (hold_cnt_q == HOLD_FULL) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
          end
          if (btn_db_q && hold_cnt_q == HOLD_FULL) begin
            if (div_cnt_q == MED_LAST) begin
              div_cnt_d    = '0;
              cpu_clk_en_d = 1'b1;
            end else begin
              div_cnt_d = div_cnt_q + DIV_W'(1);
            end
          end else begin
            div_cnt_d = '0;
          end
`endif
        end
        SLOW: begin
          if (div_cnt_q == SLOW_LAST) begin
            div_cnt_d    = '0;
            cpu_clk_en_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        MED: begin
          if (div_cnt_q == MED_LAST) begin
            div_cnt_d    = '0;
            cpu_clk_en_d = 1'b1;
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
        FREE: begin
          cpu_clk_en_d = 1'b1;
        end
        default: begin
          cpu_clk_en_d = 1'b0;
        end
      endcase
    end
  end

  // The LED and the counter advance on the same edge that raises cpu_clk_en.
  assign tick_led_d   = tick_led_q ^ cpu_clk_en_d;
  assign step_count_d = step_count_q + 32'(cpu_clk_en_d);

  // State registers: a synchronous reset clears everything, including the
  // synchronizers and debounce state, so pending work is discarded.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the edge regardless of statement order.
    if (rst_i) begin
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      mode_meta_q   <= 2'b00;
      mode_s_q      <= 2'b00;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      step_req_q    <= 1'b0;
      mode_q        <= MANUAL;
      div_cnt_q     <= '0;
      cpu_clk_en_q  <= 1'b0;
      tick_led_q    <= 1'b0;
      step_count_q  <= '0;
`ifdef CLOCK_IF_BURST_EN
      hold_cnt_q    <= '0;
`endif
    end else begin
      btn_meta_q    <= step_btn_i;
      btn_s_q       <= btn_meta_q;
      mode_meta_q   <= mode_i;
      mode_s_q      <= mode_meta_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      step_req_q    <= step_req_d;
      mode_q        <= mode_d;
      div_cnt_q     <= div_cnt_d;
      cpu_clk_en_q  <= cpu_clk_en_d;
      tick_led_q    <= tick_led_d;
      step_count_q  <= step_count_d;
`ifdef CLOCK_IF_BURST_EN
      hold_cnt_q    <= hold_cnt_d;
`endif
    end
  end

  assign cpu_clk_en_o = cpu_clk_en_q;
  assign tick_led_o   = tick_led_q;
  assign step_count_o = step_count_q;

endmodule

// File: tb/tb_clock_interface.sv
// Directed testbench for clock_interface with small timing parameters
// (DEBOUNCE_CYCLES=4, SLOW_DIV=10, MED_DIV=3, BURST_HOLD=8). Inputs are driven
// just after the falling edge and outputs sampled on the falling edge, so bit i
// of each observed vector is cpu_clk_en after the i-th rising edge of a scenario.
module tb_clock_interface;

  localparam int DEB  = 4;
  localparam int SLOW = 10;
  localparam int MED  = 3;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        step_btn;
  logic        halt;
  logic        cpu_clk_en;
  logic        tick_led;
  logic [31:0] step_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  clock_interface #(
    .DEBOUNCE_CYCLES(DEB),
    .SLOW_DIV       (SLOW),
    .MED_DIV        (MED),
    .BURST_HOLD     (HOLD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .mode_i      (mode),
    .step_btn_i  (step_btn),
    .halt_i      (halt),
    .cpu_clk_en_o(cpu_clk_en),
    .tick_led_o  (tick_led),
    .step_count_o(step_count)
  );

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Three reset cycles with the switches already at the requested mode. The
  // next rising edge after return is the first one out of reset.
  task automatic do_reset(input logic [1:0] m);
    rst      = 1'b1;
    mode     = m;
    step_btn = 1'b0;
    halt     = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [63:0] obs;
    obs      = '0;
    rst      = 1'b1;
    mode     = 2'b11;
    step_btn = 1'b0;
    halt     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests_run++;
      if (cpu_clk_en !== 1'b0 || step_count !== 32'd0 || tick_led !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: en=%b count=%0d tick=%b, need en=0 count=0 tick=0",
                 i, cpu_clk_en, step_count, tick_led);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      obs[i] = cpu_clk_en;
    end
    // Sync takes two edges, mode entry one more, first free-run pulse after the fourth.
    tests_run++;
    if (obs[4:0] !== 5'b11000) begin
      tests_failed++;
      $display("FAIL reset_release_en: got %b, need %b", obs[4:0], 5'b11000);
    end
    tests_run++;
    if (step_count !== 32'd2 || tick_led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_count: count=%0d tick=%b, need count=2 tick=0",
               step_count, tick_led);
    end
  endtask

  task automatic test_manual_step();
    logic [63:0] obs;
    obs = '0;
    do_reset(2'b00);
    repeat (3) cycle();
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      obs[i] = cpu_clk_en;
    end
    // 2 sync + 4 debounce + 1 edge register: pulse after the 8th edge (index 7).
    tests_run++;
    if (obs[19:0] !== 20'h00080) begin
      tests_failed++;
      $display("FAIL manual_press_en: got %b, need %b", obs[19:0], 20'h00080);
    end
    tests_run++;
    if (step_count !== 32'd1 || tick_led !== 1'b1) begin
      tests_failed++;
      $display("FAIL manual_press_count: count=%0d tick=%b, need count=1 tick=1",
               step_count, tick_led);
    end
    step_btn = 1'b0;
    repeat (12) cycle();
    tests_run++;
    if (step_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL manual_release: count=%0d, need 1", step_count);
    end
  endtask

  task automatic test_debounce_glitch();
    logic [63:0] obs;
    obs = '0;
    do_reset(2'b00);
    repeat (3) cycle();
    // High for DEB-1 samples: must be rejected.
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == DEB - 1) step_btn = 1'b0;
      cycle();
      obs[i] = cpu_clk_en;
    end
    tests_run++;
    if (obs[19:0] !== 20'h00000 || step_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL glitch_short: en=%b count=%0d, need en=0 count=0", obs[19:0], step_count);
    end
    repeat (8) cycle();
    // High for exactly DEB samples: accepted, same latency as a long press.
    obs = '0;
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == DEB) step_btn = 1'b0;
      cycle();
      obs[i] = cpu_clk_en;
    end
    tests_run++;
    if (obs[19:0] !== 20'h00080) begin
      tests_failed++;
      $display("FAIL glitch_exact_en: got %b, need %b", obs[19:0], 20'h00080);
    end
    tests_run++;
    if (step_count !== 32'd1) begin
      tests_failed++;
      $display("FAIL glitch_exact_count: count=%0d, need 1", step_count);
    end
  endtask

  task automatic test_slow_to_med();
    logic [63:0] obs;
    logic [63:0] exp;
    obs = '0;
    // Entry at edge 2; slow pulses at 12 and 22. Switches flip before edge 25,
    // so medium entry is edge 27 and its pulses land at 30 and 33 (none at 32).
    exp = (64'd1 << 12) | (64'd1 << 22) | (64'd1 << 30) | (64'd1 << 33);
    do_reset(2'b01);
    for (int i = 0; i < 36; i++) begin
      if (i == 25) mode = 2'b10;
      cycle();
      obs[i] = cpu_clk_en;
    end
    tests_run++;
    if (obs[35:0] !== exp[35:0]) begin
      tests_failed++;
      $display("FAIL slow_med_en: got %b, need %b", obs[35:0], exp[35:0]);
    end
    tests_run++;
    if (step_count !== 32'd4 || tick_led !== 1'b0) begin
      tests_failed++;
      $display("FAIL slow_med_count: count=%0d tick=%b, need count=4 tick=0",
               step_count, tick_led);
    end
  endtask

  task automatic test_free_halt();
    logic [63:0] obs;
    logic [31:0] mid_count;
    obs       = '0;
    mid_count = '0;
    do_reset(2'b11);
    for (int i = 0; i < 20; i++) begin
      halt = (i >= 8 && i <= 12);
      cycle();
      obs[i] = cpu_clk_en;
      if (i == 12) mid_count = step_count;
    end
    halt = 1'b0;
    // Pulses after edges 3..7, gap for the five halted edges 8..12, then 13..19.
    tests_run++;
    if (obs[19:0] !== 20'hFE0F8) begin
      tests_failed++;
      $display("FAIL free_halt_en: got %b, need %b", obs[19:0], 20'hFE0F8);
    end
    tests_run++;
    if (mid_count !== 32'd5) begin
      tests_failed++;
      $display("FAIL free_halt_frozen: count=%0d at end of halt, need 5", mid_count);
    end
    tests_run++;
    if (step_count !== 32'd12 || tick_led !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_halt_count: count=%0d tick=%b, need count=12 tick=0",
               step_count, tick_led);
    end
  endtask

  task automatic test_med_halt();
    logic [63:0] obs;
    obs = '0;
    do_reset(2'b10);
    // Entry at 2, pulse at 5; halt on edges 6,7 freezes the divider, so the
    // next pulses slip two cycles to 10 and 13.
    for (int i = 0; i < 16; i++) begin
      halt = (i == 6 || i == 7);
      cycle();
      obs[i] = cpu_clk_en;
    end
    halt = 1'b0;
    tests_run++;
    if (obs[15:0] !== 16'h2420) begin
      tests_failed++;
      $display("FAIL med_halt_en: got %b, need %b", obs[15:0], 16'h2420);
    end
    tests_run++;
    if (step_count !== 32'd3 || tick_led !== 1'b1) begin
      tests_failed++;
      $display("FAIL med_halt_count: count=%0d tick=%b, need count=3 tick=1",
               step_count, tick_led);
    end
  endtask

  // Press in manual with halt asserted on edges lo..hi; the step is dropped,
  // and nothing appears after halt is released.
  task automatic test_halt_step(input int lo, input int hi);
    logic [63:0] obs;
    obs = '0;
    do_reset(2'b00);
    repeat (3) cycle();
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      halt = (i >= lo && i <= hi);
      cycle();
      obs[i] = cpu_clk_en;
    end
    halt = 1'b0;
    repeat (10) cycle();
    step_btn = 1'b0;
    tests_run++;
    if (obs[19:0] !== 20'h00000 || step_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL halt_step[%0d..%0d]: en=%b count=%0d, need en=0 count=0",
               lo, hi, obs[19:0], step_count);
    end
  endtask

  task automatic test_wrap();
    do_reset(2'b00);
    repeat (3) cycle();
    force dut.step_count_q = 32'hFFFF_FFFF;
    cycle();
    release dut.step_count_q;
    cycle();
    tests_run++;
    if (step_count !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL wrap_preload: count=%h, need ffffffff", step_count);
    end
    step_btn = 1'b1;
    repeat (10) cycle();
    step_btn = 1'b0;
    tests_run++;
    if (step_count !== 32'd0 || tick_led !== 1'b1) begin
      tests_failed++;
      $display("FAIL wrap_rollover: count=%h tick=%b, need count=00000000 tick=1",
               step_count, tick_led);
    end
  endtask

  initial begin
    rst      = 1'b1;
    mode     = 2'b00;
    step_btn = 1'b0;
    halt     = 1'b0;
    @(negedge clk);
    test_reset();
    test_manual_step();
    test_debounce_glitch();
    test_slow_to_med();
    test_free_halt();
    test_med_halt();
    test_halt_step(0, 15);
    test_halt_step(7, 7);
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
